// File: rtl/fp_pkg.sv
// Shared types and constants for the sequential floating-point divider.
package fp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_DIVIDE,
        ST_NORM,
        ST_ROUND,
        ST_DONE
    } state_t;

    // Rounding-mode encodings; any other code behaves as RNE.
    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;

    // Bit positions inside fflags = {NV,DZ,OF,UF,NX}.
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    // Exponent bias for a given exponent width.
    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN (sign 0, exponent all ones, fraction MSB set),
    // returned wide and truncated by the caller to its word width.
    function automatic logic [127:0] fp_canon_nan(input int exp_w, input int man_w);
        logic [127:0] v;
        v = ((128'd1 << exp_w) - 128'd1) << man_w;
        v = v | (128'd1 << (man_w - 1));
        return v;
    endfunction

endpackage

// File: rtl/fp_sig_divider.sv
// Restoring radix-2 significand divider, one quotient bit per clock.
// done is high during the cycle of the final iteration; quotient and
// rem_nz are valid from the following cycle until the next start.
module fp_sig_divider #(
    parameter int SIG_W = 24,
    parameter int ITER  = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SIG_W-1:0] dividend,
    input  logic [SIG_W-1:0] divisor,
    output logic             done,
    output logic [ITER-1:0]  quotient,
    output logic             rem_nz
);

    localparam int CNT_W = $clog2(ITER + 1);

    logic [SIG_W:0]   rem_q, rem_d;
    logic [SIG_W-1:0] div_q, div_d;
    logic [ITER-1:0]  quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SIG_W:0]   diff;
    logic [SIG_W:0]   kept;
    logic             ge;

    // Load on start, otherwise one compare/subtract/shift step per cycle.
    always_comb begin
        rem_d = rem_q;
        div_d = div_q;
        quo_d = quo_q;
        cnt_d = cnt_q;
        ge    = (rem_q >= {1'b0, div_q});
        diff  = rem_q - {1'b0, div_q};
        kept  = ge ? diff : rem_q;
        if (start) begin
            rem_d = {1'b0, dividend};
            div_d = divisor;
            quo_d = '0;
            cnt_d = CNT_W'(ITER);
        end else if (cnt_q != '0) begin
            quo_d = {quo_q[ITER-2:0], ge};
            // kept < divisor, so its MSB is always zero and may be dropped.
            rem_d = {kept[SIG_W-1:0], 1'b0};
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            div_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            div_q <= div_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
        end
    end

    assign done     = (cnt_q == CNT_W'(1));
    assign quotient = quo_q;
    assign rem_nz   = |rem_q;

endmodule

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 divider: unpack/specials, restoring significand
// division, normalise, round in four modes, FTZ on inputs and output.
module fp_div_seq
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   op_a,
    input  logic [EXP_W+MAN_W:0]   op_b,
    input  logic [2:0]             rm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [4:0]             fflags
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SIG_W = MAN_W + 1;
    localparam int ITER  = MAN_W + 4;
    localparam int EW    = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS_S  = EW'(fp_bias(EXP_W));
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]     CANON_NAN = W'(fp_canon_nan(EXP_W, MAN_W));
    localparam logic [EXP_W-1:0] EXP_ONES  = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_MAXF  = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [MAN_W-1:0] MAN_ZERO  = {MAN_W{1'b0}};
    localparam logic [MAN_W-1:0] MAN_ONES  = {MAN_W{1'b1}};

    state_t                 state_q, state_d;
    logic [W-1:0]           op_a_q, op_a_d, op_b_q, op_b_d;
    logic [2:0]             rm_q, rm_d;
    logic                   sign_q, sign_d;
    logic signed [EW-1:0]   exp_q, exp_d;
    logic [MAN_W-1:0]       frac_q, frac_d;
    logic                   guard_q, guard_d, sticky_q, sticky_d;
    logic [W-1:0]           result_q, result_d;
    logic [4:0]             fflags_q, fflags_d;

    logic                   sa, sb, sq;
    logic [EXP_W-1:0]       ea, eb;
    logic [MAN_W-1:0]       fa, fb;
    logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic signed [EW-1:0]   e_unpack;

    logic                   div_start, div_done, div_rem_nz;
    logic [ITER-1:0]        div_quo;

    assign sa = op_a_q[W-1];
    assign sb = op_b_q[W-1];
    assign sq = sa ^ sb;
    assign ea = op_a_q[W-2 -: EXP_W];
    assign eb = op_b_q[W-2 -: EXP_W];
    assign fa = op_a_q[MAN_W-1:0];
    assign fb = op_b_q[MAN_W-1:0];

    // Zero exponent covers subnormals too: they are flushed to zero.
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == EXP_ONES) && (fa == '0);
    assign b_inf  = (eb == EXP_ONES) && (fb == '0);
    assign a_nan  = (ea == EXP_ONES) && (fa != '0);
    assign b_nan  = (eb == EXP_ONES) && (fb != '0);
    assign e_unpack = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_S;

    fp_sig_divider #(
        .SIG_W (SIG_W),
        .ITER  (ITER)
    ) u_sig_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend ({1'b1, fa}),
        .divisor  ({1'b1, fb}),
        .done     (div_done),
        .quotient (div_quo),
        .rem_nz   (div_rem_nz)
    );

    // Special-operand classification in priority order.
    logic         is_special;
    logic [W-1:0] special_res;
    logic [4:0]   special_flags;
    always_comb begin
        is_special    = 1'b1;
        special_res   = '0;
        special_flags = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            special_res            = CANON_NAN;
            special_flags[FLAG_NV] = 1'b1;
        end else if (a_inf) begin
            special_res = {sq, EXP_ONES, MAN_ZERO};
        end else if (b_zero) begin
            special_res            = {sq, EXP_ONES, MAN_ZERO};
            special_flags[FLAG_DZ] = 1'b1;
        end else if (b_inf || a_zero) begin
            special_res = {sq, {(W-1){1'b0}}};
        end else begin
            is_special = 1'b0;
        end
    end

    // Normalise the quotient from (0.5,2) into [1,2); hidden bit is implied.
    logic [MAN_W-1:0]     norm_frac;
    logic                 norm_guard, norm_sticky;
    logic signed [EW-1:0] norm_exp;
    always_comb begin
        norm_exp = exp_q;
        if (div_quo[ITER-1]) begin
            norm_frac   = div_quo[ITER-2 -: MAN_W];
            norm_guard  = div_quo[2];
            norm_sticky = div_quo[1] | div_quo[0] | div_rem_nz;
        end else begin
            norm_frac   = div_quo[ITER-3 -: MAN_W];
            norm_guard  = div_quo[1];
            norm_sticky = div_quo[0] | div_rem_nz;
            norm_exp    = exp_q - EW'(1);
        end
    end

    // Round, then detect overflow/underflow on the rounded exponent.
    logic                 round_inc, round_carry, inexact, ovf_inf;
    logic [MAN_W-1:0]     round_frac;
    logic signed [EW-1:0] round_exp;
    logic [W-1:0]         round_res;
    logic [4:0]           round_flags;
    always_comb begin
        inexact = guard_q | sticky_q;
        case (rm_q)
            RM_RTZ:  round_inc = 1'b0;
            RM_RDN:  round_inc = inexact & sign_q;
            RM_RUP:  round_inc = inexact & ~sign_q;
            default: round_inc = guard_q & (sticky_q | frac_q[0]);
        endcase
        case (rm_q)
            RM_RTZ:  ovf_inf = 1'b0;
            RM_RDN:  ovf_inf = sign_q;
            RM_RUP:  ovf_inf = ~sign_q;
            default: ovf_inf = 1'b1;
        endcase
        // A carry out of the fraction means the significand became 2.0.
        {round_carry, round_frac} = {1'b0, frac_q} + {{MAN_W{1'b0}}, round_inc};
        round_exp   = exp_q + $signed({{(EW-1){1'b0}}, round_carry});
        round_res   = {sign_q, round_exp[EXP_W-1:0], round_frac};
        round_flags = '0;
        round_flags[FLAG_NX] = inexact;
        if (round_exp >= EXP_MAX) begin
            round_res = ovf_inf ? {sign_q, EXP_ONES, MAN_ZERO}
                                : {sign_q, EXP_MAXF, MAN_ONES};
            round_flags[FLAG_OF] = 1'b1;
            round_flags[FLAG_NX] = 1'b1;
        end else if (round_exp[EW-1] || (round_exp == '0)) begin
            round_res = {sign_q, {(W-1){1'b0}}};
            round_flags[FLAG_UF] = 1'b1;
            round_flags[FLAG_NX] = 1'b1;
        end
    end

    // FSM next-state and datapath register updates.
    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        rm_d      = rm_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        frac_d    = frac_q;
        guard_d   = guard_q;
        sticky_d  = sticky_q;
        result_d  = result_q;
        fflags_d  = fflags_q;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_a_d  = op_a;
                    op_b_d  = op_b;
                    rm_d    = rm;
                    state_d = ST_UNPACK;
                end
            end
            ST_UNPACK: begin
                if (is_special) begin
                    result_d = special_res;
                    fflags_d = special_flags;
                    state_d  = ST_DONE;
                end else begin
                    sign_d    = sq;
                    exp_d     = e_unpack;
                    div_start = 1'b1;
                    state_d   = ST_DIVIDE;
                end
            end
            ST_DIVIDE: begin
                if (div_done) begin
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                exp_d    = norm_exp;
                frac_d   = norm_frac;
                guard_d  = norm_guard;
                sticky_d = norm_sticky;
                state_d  = ST_ROUND;
            end
            ST_ROUND: begin
                result_d = round_res;
                fflags_d = round_flags;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            rm_q     <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            frac_q   <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            result_q <= '0;
            fflags_q <= '0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            rm_q     <= rm_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            frac_q   <= frac_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            result_q <= result_d;
            fflags_q <= fflags_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign fflags    = fflags_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq: single precision plus a double-precision instance.
module tb_fp_div_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b0;
    logic [31:0] s_op_a = '0, s_op_b = '0, s_result;
    logic [2:0]  s_rm = '0;
    logic [4:0]  s_fflags;

    logic        d_in_valid = 1'b0, d_in_ready, d_out_valid, d_out_ready = 1'b0;
    logic [63:0] d_op_a = '0, d_op_b = '0, d_result;
    logic [2:0]  d_rm = '0;
    logic [4:0]  d_fflags;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fp_div_seq #(.EXP_W(8), .MAN_W(23)) u_sp (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .op_a(s_op_a), .op_b(s_op_b), .rm(s_rm), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .result(s_result), .fflags(s_fflags)
    );

    fp_div_seq #(.EXP_W(11), .MAN_W(52)) u_dp (
        .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .op_a(d_op_a), .op_b(d_op_b), .rm(d_rm), .out_valid(d_out_valid),
        .out_ready(d_out_ready), .result(d_result), .fflags(d_fflags)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sp_start(input logic [31:0] a, input logic [31:0] b, input logic [2:0] r);
        @(negedge clk);
        chk("sp_in_ready_before", 64'(s_in_ready), 64'd1);
        s_op_a = a; s_op_b = b; s_rm = r; s_in_valid = 1'b1;
        @(posedge clk);
        #1 s_in_valid = 1'b0;
    endtask

    // Called #1 after the handshake edge, i.e. in cycle T+1.
    task automatic sp_wait(input logic [31:0] er, input logic [4:0] ef, input int elat, input string tag);
        int lat = 1;
        while (!s_out_valid && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(elat));
        chk({tag, "_result"}, 64'(s_result), 64'(er));
        chk({tag, "_fflags"}, 64'(s_fflags), 64'(ef));
        $display("sp %s: result=%h fflags=%h latency=%0d", tag, s_result, s_fflags, lat);
    endtask

    task automatic sp_ack();
        s_out_ready = 1'b1;
        @(posedge clk);
        #1 s_out_ready = 1'b0;
        chk("sp_in_ready_after_ack", 64'(s_in_ready), 64'd1);
    endtask

    task automatic sp_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] r,
                         input logic [31:0] er, input logic [4:0] ef, input int elat, input string tag);
        sp_start(a, b, r);
        sp_wait(er, ef, elat, tag);
        sp_ack();
    endtask

    task automatic dp_op(input logic [63:0] a, input logic [63:0] b, input logic [2:0] r,
                         input logic [63:0] er, input logic [4:0] ef, input int elat, input string tag);
        int lat = 1;
        @(negedge clk);
        chk("dp_in_ready_before", 64'(d_in_ready), 64'd1);
        d_op_a = a; d_op_b = b; d_rm = r; d_in_valid = 1'b1;
        @(posedge clk);
        #1 d_in_valid = 1'b0;
        while (!d_out_valid && lat < 300) begin
            @(posedge clk);
            #1 lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(elat));
        chk({tag, "_result"}, d_result, er);
        chk({tag, "_fflags"}, 64'(d_fflags), 64'(ef));
        $display("dp %s: result=%h fflags=%h latency=%0d", tag, d_result, d_fflags, lat);
        d_out_ready = 1'b1;
        @(posedge clk);
        #1 d_out_ready = 1'b0;
        chk("dp_in_ready_after_ack", 64'(d_in_ready), 64'd1);
    endtask

    initial begin
        bit stable;

        // Reset values while held in reset.
        #12;
        chk("rst_sp_in_ready", 64'(s_in_ready), 64'd1);
        chk("rst_sp_out_valid", 64'(s_out_valid), 64'd0);
        chk("rst_sp_result", 64'(s_result), 64'd0);
        chk("rst_sp_fflags", 64'(s_fflags), 64'd0);
        chk("rst_dp_in_ready", 64'(d_in_ready), 64'd1);
        chk("rst_dp_out_valid", 64'(d_out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Main function and rounding modes.
        sp_op(32'h40C00000, 32'h40000000, 3'b000, 32'h40400000, 5'h00, 31, "six_div_two");
        sp_op(32'h3F800000, 32'h40400000, 3'b000, 32'h3EAAAAAB, 5'h01, 31, "third_rne");
        sp_op(32'h3F800000, 32'h40400000, 3'b001, 32'h3EAAAAAA, 5'h01, 31, "third_rtz");
        sp_op(32'h3F800000, 32'h40400000, 3'b011, 32'h3EAAAAAB, 5'h01, 31, "third_rup");
        sp_op(32'hBF800000, 32'h40400000, 3'b010, 32'hBEAAAAAB, 5'h01, 31, "neg_third_rdn");
        sp_op(32'hBF800000, 32'h40400000, 3'b011, 32'hBEAAAAAA, 5'h01, 31, "neg_third_rup");

        // Specials.
        sp_op(32'h3F800000, 32'h00000000, 3'b000, 32'h7F800000, 5'h08, 2, "one_div_zero");
        sp_op(32'h00000000, 32'h00000000, 3'b000, 32'h7FC00000, 5'h10, 2, "zero_div_zero");
        sp_op(32'h7F800000, 32'h7F800000, 3'b000, 32'h7FC00000, 5'h10, 2, "inf_div_inf");
        sp_op(32'h7FC00000, 32'h3F800000, 3'b000, 32'h7FC00000, 5'h10, 2, "qnan_div_one");

        // Range limits.
        sp_op(32'h7F7FFFFF, 32'h3F000000, 3'b000, 32'h7F800000, 5'h05, 31, "overflow_rne");
        sp_op(32'h7F7FFFFF, 32'h3F000000, 3'b001, 32'h7F7FFFFF, 5'h05, 31, "overflow_rtz");
        sp_op(32'h80800000, 32'h40000000, 3'b000, 32'h80000000, 5'h03, 31, "underflow");

        // Backpressure: result held, in_valid ignored while not idle.
        sp_start(32'h40C00000, 32'h40000000, 3'b000);
        sp_wait(32'h40400000, 5'h00, 31, "bp_first");
        s_op_a = 32'h3F800000; s_op_b = 32'h40400000; s_rm = 3'b001; s_in_valid = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (!s_out_valid || s_in_ready || s_result !== 32'h40400000 || s_fflags !== 5'h00)
                stable = 1'b0;
        end
        chk("bp_hold_stable", 64'(stable), 64'd1);
        s_out_ready = 1'b1;
        @(posedge clk);
        #1 s_out_ready = 1'b0;
        chk("bp_release_out_valid", 64'(s_out_valid), 64'd0);
        chk("bp_release_in_ready", 64'(s_in_ready), 64'd1);
        @(posedge clk);
        #1 s_in_valid = 1'b0;
        sp_wait(32'h3EAAAAAA, 5'h01, 31, "bp_second");
        sp_ack();

        // Reset in the middle of a division.
        sp_start(32'h3F800000, 32'h40400000, 3'b000);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(s_out_valid), 64'd0);
        chk("midrst_in_ready", 64'(s_in_ready), 64'd1);
        chk("midrst_result", 64'(s_result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (s_out_valid || !s_in_ready) stable = 1'b0;
        end
        chk("postrst_idle_no_stale", 64'(stable), 64'd1);
        sp_op(32'h40C00000, 32'h40000000, 3'b000, 32'h40400000, 5'h00, 31, "postrst_six_div_two");

        // Double-precision instance.
        dp_op(64'h4018000000000000, 64'h4000000000000000, 3'b000,
              64'h4008000000000000, 5'h00, 60, "dp_six_div_two");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
